// File: rtl/pipe_pkg.sv
// Shared types and per-stage widths for the inter-stage pipeline registers.
package pipe_pkg;

    // Occupancy state of a skid-buffered stage register.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    // IF/ID: instruction word, PC, PC+4.
    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned IF_ID_DATA_W  = 96;
    // ID/EX: decoded controls plus rs1/rs2 values, immediate, PC, PC+4, rd.
    localparam int unsigned ID_EX_CTRL_W  = 12;
    localparam int unsigned ID_EX_DATA_W  = 165;
    // EX/MEM: regWrite, memWrite, resultSrc plus ALU result, store data, PC+4, rd.
    localparam int unsigned EX_MEM_CTRL_W = 4;
    localparam int unsigned EX_MEM_DATA_W = 101;
    // MEM/WB: regWrite, resultSrc plus ALU result, load data, imm, PC+4, rd.
    localparam int unsigned MEM_WB_CTRL_W = 3;
    localparam int unsigned MEM_WB_DATA_W = 133;

    // Number of entries held in a given FSM state.
    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        unique case (s)
            PS_EMPTY: occ = 2'd0;
            PS_BUSY:  occ = 2'd1;
            PS_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control field and payload.
// The control field reads as zero whenever the slot is empty so a bubble
// can never assert a write enable downstream.
module pipe_slot #(
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned DATA_W = 133
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Priority: reset clears everything, flush only kills the entry, load beats drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= in_ctrl;
            data_q  <= in_data;
        end else if (drop) begin
            valid_q <= 1'b0;
        end
    end

    // Mask control on an empty slot; payload is left as-is.
    always_comb begin
        valid = valid_q;
        ctrl  = valid_q ? ctrl_q : '0;
        data  = data_q;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and
// control-field bubble masking. SKID=1 adds a second entry so in_ready can
// be driven from a flop instead of from out_ready.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned DATA_W = 133,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    import pipe_pkg::*;

    if (CTRL_W < 1 || DATA_W < 1 || SKID > 1) begin : gen_param_err
        $error("pipe_stage_reg: need CTRL_W >= 1, DATA_W >= 1 and SKID in {0,1}");
    end

    logic              xfer_in;
    logic              xfer_out;
    logic              main_load;
    logic              main_drop;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    // The main slot always drives the stage outputs.
    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (main_load),
        .drop    (main_drop),
        .in_ctrl (main_ctrl_in),
        .in_data (main_data_in),
        .valid   (main_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    assign out_valid = main_valid;
    assign xfer_out  = main_valid && out_ready;

    if (SKID == 0) begin : gen_single

        // Single register: ready when empty or when the held entry leaves now.
        always_comb begin
            in_ready     = !main_valid || out_ready;
            xfer_in      = in_valid && in_ready;
            main_load    = xfer_in;
            main_drop    = xfer_out;
            main_ctrl_in = in_ctrl;
            main_data_in = in_data;
            occupancy    = {1'b0, main_valid};
        end

    end else begin : gen_skid

        pipe_state_e       state_q, state_d;
        logic              in_ready_q;
        logic              skid_load;
        logic              skid_drop;
        logic              skid_valid;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        // Second entry catches the beat accepted while the main slot is stalled.
        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load    (skid_load),
            .drop    (skid_drop),
            .in_ctrl (in_ctrl),
            .in_data (in_data),
            .valid   (skid_valid),
            .ctrl    (skid_ctrl),
            .data    (skid_data)
        );

        // skid_valid mirrors state_q == PS_FULL; kept for slot symmetry only.
        logic unused_skid_valid;
        assign unused_skid_valid = skid_valid;

        // Next state and slot load/drop strobes; flush overrides every transfer.
        always_comb begin
            state_d      = state_q;
            main_load    = 1'b0;
            main_drop    = 1'b0;
            skid_load    = 1'b0;
            skid_drop    = 1'b0;
            main_ctrl_in = in_ctrl;
            main_data_in = in_data;
            xfer_in      = in_valid && in_ready_q;

            unique case (state_q)
                PS_EMPTY: begin
                    if (xfer_in) begin
                        main_load = 1'b1;
                        state_d   = PS_BUSY;
                    end
                end
                PS_BUSY: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_in) begin
                        skid_load = 1'b1;
                        state_d   = PS_FULL;
                    end else if (xfer_out) begin
                        main_drop = 1'b1;
                        state_d   = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // in_ready_q is low here, so only the drain side can move.
                    if (xfer_out) begin
                        main_load    = 1'b1;
                        main_ctrl_in = skid_ctrl;
                        main_data_in = skid_data;
                        skid_drop    = 1'b1;
                        state_d      = PS_BUSY;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase

            if (flush) begin
                state_d = PS_EMPTY;
            end
        end

        // State register; in_ready is precomputed from the next state.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= PS_EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                in_ready_q <= (state_d != PS_FULL);
            end
        end

        assign in_ready  = in_ready_q;
        assign occupancy = state_occupancy(state_q);

    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a SKID=1 instance runs the main directed sequence and a
// SKID=0 instance runs the toggling-stall regression.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 3;
    localparam int unsigned DW = 133;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    logic          clk;
    logic          rst;
    logic          flush;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    logic          in_valid0, in_ready0, out_valid0, out_ready0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0]    occupancy0;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_out    = 0;
    int     n_out0   = 0;
    bit     mon_en   = 1'b0;
    entry_t sb[$];
    entry_t sb0[$];

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .SKID   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .SKID   (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_ctrl   (in_ctrl0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_ctrl  (out_ctrl0),
        .out_data  (out_data0),
        .occupancy (occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SKID=1 scoreboard: pop on transfer out, push on accepted transfer in.
    always @(negedge clk) begin
        entry_t e;
        if (mon_en) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("s1_spurious_out", DW'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("s1_out_data", out_data, e.d);
                    check("s1_out_ctrl", DW'(out_ctrl), DW'(e.c));
                end
            end
            if (!out_valid) check("s1_bubble_ctrl", DW'(out_ctrl), 0);
            if (rst || flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back('{c: in_ctrl, d: in_data});
        end
    end

    // SKID=0 scoreboard.
    always @(negedge clk) begin
        entry_t e;
        if (mon_en) begin
            if (out_valid0 && out_ready0) begin
                n_out0++;
                if (sb0.size() == 0) begin
                    check("s0_spurious_out", DW'(sb0.size()), 1);
                end else begin
                    e = sb0.pop_front();
                    check("s0_out_data", out_data0, e.d);
                    check("s0_out_ctrl", DW'(out_ctrl0), DW'(e.c));
                end
            end
            if (!out_valid0) check("s0_bubble_ctrl", DW'(out_ctrl0), 0);
            if (rst || flush) sb0.delete();
            else if (in_valid0 && in_ready0) sb0.push_back('{c: in_ctrl0, d: in_data0});
        end
    end

    initial begin
        logic [DW-1:0] nxt;

        // Reset with a live upstream entry that must not get in.
        rst = 1'b1;  flush = 1'b0;
        in_valid  = 1'b1; in_ctrl  = 3'b111; in_data  = DW'(133'h55); out_ready  = 1'b0;
        in_valid0 = 1'b1; in_ctrl0 = 3'b111; in_data0 = DW'(133'h55); out_ready0 = 1'b0;
        step();
        mon_en = 1'b1;
        check("rst_out_valid", DW'(out_valid), 0);
        check("rst_out_ctrl", DW'(out_ctrl), 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", DW'(occupancy), 0);
        check("rst_in_ready", DW'(in_ready), 1);
        check("rst0_out_valid", DW'(out_valid0), 0);
        check("rst0_out_data", out_data0, 0);
        check("rst0_in_ready", DW'(in_ready0), 1);
        step();
        check("rst2_occupancy", DW'(occupancy), 0);
        rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;

        // Back-to-back streaming 1..8.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = 3'(i); in_data = DW'(i);
            step();
            check("stream_valid", DW'(out_valid), 1);
            check("stream_data", out_data, DW'(i));
            check("stream_in_ready", DW'(in_ready), 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", DW'(out_valid), 0);
        check("stream_drain_occ", DW'(occupancy), 0);

        // Stall with A, B, C.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'd1; in_data = DW'(133'hA);
        step();
        check("stall_a_occ", DW'(occupancy), 1);
        check("stall_a_ready", DW'(in_ready), 1);
        in_ctrl = 3'd2; in_data = DW'(133'hB);
        step();
        check("stall_b_occ", DW'(occupancy), 2);
        check("stall_b_ready", DW'(in_ready), 0);
        check("stall_b_head", out_data, DW'(133'hA));
        in_ctrl = 3'd3; in_data = DW'(133'hC);
        step();
        check("stall_c_held_occ", DW'(occupancy), 2);
        check("stall_c_held_head", out_data, DW'(133'hA));
        out_ready = 1'b1;
        step();
        check("release_b_head", out_data, DW'(133'hB));
        check("release_ready", DW'(in_ready), 1);
        check("release_occ", DW'(occupancy), 1);
        step();
        check("release_c_head", out_data, DW'(133'hC));
        in_valid = 1'b0;
        step();
        check("release_empty_occ", DW'(occupancy), 0);

        // Flush while FULL with C' presented upstream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'd4; in_data = DW'(133'hD);
        step();
        in_ctrl = 3'd6; in_data = DW'(133'hE);
        step();
        check("pre_flush_occ", DW'(occupancy), 2);
        flush = 1'b1; in_ctrl = 3'd7; in_data = DW'(133'hF);
        step();
        check("flush_out_valid", DW'(out_valid), 0);
        check("flush_occ", DW'(occupancy), 0);
        check("flush_in_ready", DW'(in_ready), 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("post_flush_valid1", DW'(out_valid), 0);
        step();
        check("post_flush_valid2", DW'(out_valid), 0);

        // Bubble masking.
        in_valid = 1'b1; in_ctrl = 3'b101; in_data = DW'(133'h77);
        step();
        check("bubble_live_ctrl", DW'(out_ctrl), DW'(3'b101));
        in_valid = 1'b0;
        step();
        check("bubble_valid", DW'(out_valid), 0);
        check("bubble_ctrl", DW'(out_ctrl), 0);

        // SKID=0: continuous stream, out_ready toggling 1,0,1,0,...
        nxt = DW'(1);
        for (int j = 0; j < 8; j++) begin
            in_valid0 = 1'b1; in_data0 = nxt; in_ctrl0 = 3'(j + 1);
            out_ready0 = (j % 2 == 0);
            #1;
            check("s0_in_ready", DW'(in_ready0), DW'(j % 2 == 0));
            step();
            check("s0_out_valid", DW'(out_valid0), 1);
            if (j % 2 == 0) nxt = nxt + 1;
        end
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        step();
        step();
        check("s0_drain_valid", DW'(out_valid0), 0);

        step();
        check("s1_total_out", DW'(n_out), 12);
        check("s0_total_out", DW'(n_out0), 4);
        check("s1_sb_empty", DW'(sb.size()), 0);
        check("s0_sb_empty", DW'(sb0.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
